syntax_rr_arbiter: RTL and testbench
====================================

// Module: syntax_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one WIDTH-bit data path among NUM_REQ requesters.
//  Each requester has a valid/ready port; the winner's word is captured into a one-entry
//  output register and presented downstream via valid/ready (feeds the data_in path of syntax_test).
//  Includes a stall watchdog that aborts a transfer the consumer never accepts.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..16)
//  WIDTH    8   data word width
//  TIMEOUT  16  consecutive stalled cycles before abort; 0 disables watchdog
//  CNT_W    8   width of per-requester grant counters (SYNTAX_ARB_STATS_EN only)
// PORTS
//  clk          input   1               clock, all state on posedge
//  rst_n        input   1               asynchronous active-low reset
//  req_valid    input   NUM_REQ         requester i has a word
//  req_data     input   NUM_REQ*WIDTH   word of requester i at [i*WIDTH +: WIDTH]
//  req_ready    output  NUM_REQ         one-hot accept; word i taken this cycle
//  out_valid    output  1               out_data/out_src valid
//  out_ready    input   1               downstream accepts this cycle
//  out_data     output  WIDTH           granted word
//  out_src      output  $clog2(NUM_REQ) index of requester that supplied out_data
//  busy         output  1               FSM not IDLE
//  timeout_err  output  1               one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_src=0, timeout_err=0, busy=0, FSM=IDLE,
//   rr pointer=NUM_REQ-1 (requester 0 has first priority), stall counter=0.
//  req_ready combinational: 0 while rst_n low; else one-hot on winner when
//   can_load = (state==IDLE) || (out_valid && out_ready); at most one bit set.
//  Winner: first i with req_valid[i], searching ptr+1, ptr+2 ... wrapping modulo NUM_REQ.
//  Accept in cycle N (req_valid[i] && req_ready[i]) -> out_valid=1, out_data=word,
//   out_src=i in cycle N+1; ptr<=i. Latency 1 cycle; back-to-back accepts give 1 word/cycle.
//  FSM IDLE: no output held. Accept -> XFER; else stay.
//  FSM XFER: out_valid=1; out_data/out_src stable until out_ready.
//   out_ready && new accept same cycle -> stay XFER with new word (no bubble).
//   out_ready && no req_valid -> IDLE, out_valid=0 next cycle.
//  Watchdog (TIMEOUT>0): stall counter increments each cycle out_valid && !out_ready,
//   clears on handshake or entry to IDLE. When counter reaches TIMEOUT-1 while still
//   stalled: next cycle out_valid=0, timeout_err=1 for one cycle, FSM=IDLE, word dropped;
//   ptr unchanged (still points at dropped source, so it has lowest next priority).
//  req_ready is 0 in the abort cycle; arbitration resumes the cycle after.
//  req_valid deasserting without req_ready is legal (no stickiness); arbiter holds no request state.
//  Reset asserted mid-transfer: held word discarded, all outputs to reset values immediately.
// CONFIGURATION
//  SYNTAX_ARB_STATS_EN defined: adds output grant_cnt [NUM_REQ*CNT_W]; field i increments on
//   each accept from requester i, saturates at 2**CNT_W-1, resets to 0; aborted words still count.
//  Undefined: port and counters absent; all other behaviour identical.
// TESTING (NUM_REQ=4, WIDTH=8, TIMEOUT=16, out_ready=1 unless stated)
//  Reset release, req_valid=4'b0000 -> req_ready=0, out_valid=0, busy=0 for 10 cycles.
//  req_valid=4'b1111 held, data 8'hA0..A3 -> out_src 0,1,2,3,0 on consecutive cycles, no bubbles.
//  Only req 2 valid (8'h5C) one cycle -> out_valid cycle N+1, out_data=8'h5C, out_src=2; IDLE at N+2.
//  out_ready=0 with word held -> out_data stable 15 cycles; 16th stall -> timeout_err pulse,
//   out_valid=0; then req_valid=4'b0101 with ptr=2 -> req 0 granted first.
//  rst_n low during XFER -> out_valid=0, busy=0 asynchronously; req 0 wins first after release.
//  SYNTAX_ARB_STATS_EN, CNT_W=2: 5 accepts from req 1 -> grant_cnt[1]=3 (saturated), others 0.

Source files
------------

// File: rtl/syntax_rr_arbiter_if.sv
// syntax_rr_arbiter_if: requester-side and downstream valid/ready bundle for syntax_rr_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface syntax_rr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
);
   localparam int SW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         out_data;
   logic [SW-1:0]            out_src;
   modport slave  (input  req_valid, req_data, out_ready, output req_ready, out_valid, out_data, out_src);
   modport master (output req_valid, req_data, out_ready, input  req_ready, out_valid, out_data, out_src);
endinterface

// File: rtl/syntax_rr_arbiter.sv
// syntax_rr_arbiter: round-robin NUM_REQ-to-1 arbiter with a one-entry output register and stall watchdog.
// Define SYNTAX_ARB_STATS_EN to add saturating per-requester grant counters on o_grant_cnt.
module syntax_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   syntax_rr_arbiter_if.slave bus,
   output logic               o_busy,
   output logic               o_timeout_err
`ifdef SYNTAX_ARB_STATS_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0] o_grant_cnt
`endif
);
   localparam int SW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   typedef enum logic {IDLE, XFER} state_t;
   state_t             r_state, w_next;
   logic [SW-1:0]      r_ptr, r_src, w_win;
   logic [WIDTH-1:0]   r_data;
   logic [TW-1:0]      r_cnt;
   logic               r_terr, w_found, w_can_load, w_accept, w_stall, w_abort;
   logic [NUM_REQ-1:0] w_grant;
   always_comb begin
      w_found = 1'b0;
      w_win   = r_ptr;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!w_found && bus.req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
            w_found = 1'b1;
            w_win   = SW'((int'(r_ptr) + k) % NUM_REQ);
         end
      end
   end
   // no grant in the cycle the watchdog pulse is shown
   assign w_can_load = (r_state == IDLE) || (bus.out_ready && r_state == XFER);
   assign w_grant    = (w_found && w_can_load && !r_terr && i_rst_n) ? NUM_REQ'(1) << w_win : '0;
   assign w_accept   = |w_grant;
   assign w_stall    = (r_state == XFER) && !bus.out_ready;
   assign w_abort    = (TIMEOUT > 0) && w_stall && (r_cnt == TW'(TIMEOUT - 1));
   always_comb begin
      w_next = r_state;
      if (w_accept) w_next = XFER;
      else if (w_abort || (r_state == XFER && bus.out_ready)) w_next = IDLE;
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= IDLE;
      else r_state <= w_next;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_ptr  <= SW'(NUM_REQ - 1);
         r_src  <= '0;
         r_data <= '0;
         r_cnt  <= '0;
         r_terr <= 1'b0;
      end else begin
         r_terr <= w_abort;
         r_cnt  <= (TIMEOUT > 0 && w_stall && !w_abort) ? r_cnt + 1'b1 : '0;
         if (w_accept) begin
            r_ptr  <= w_win;
            r_src  <= w_win;
            r_data <= bus.req_data[w_win*WIDTH +: WIDTH];
         end
      end
   assign bus.req_ready  = w_grant;
   assign bus.out_valid  = (r_state == XFER);
   assign bus.out_data   = r_data;
   assign bus.out_src    = r_src;
   assign o_busy         = (r_state != IDLE);
   assign o_timeout_err  = r_terr;
`ifdef SYNTAX_ARB_STATS_EN
   logic [NUM_REQ*CNT_W-1:0] r_gcnt;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_gcnt <= '0;
      else
         for (int i = 0; i < NUM_REQ; i++)
            if (w_grant[i] && !(&r_gcnt[i*CNT_W +: CNT_W]))
               r_gcnt[i*CNT_W +: CNT_W] <= r_gcnt[i*CNT_W +: CNT_W] + 1'b1;
   assign o_grant_cnt = r_gcnt;
`endif
endmodule

// File: tb/tb_syntax_rr_arbiter.sv
// tb_syntax_rr_arbiter: directed stimulus with a queue scoreboard for syntax_rr_arbiter.
// Stimulus pushes expected words; a negedge monitor pops on each handshake or watchdog abort.
module tb_syntax_rr_arbiter;
   localparam int NR = 4;
   localparam int W  = 8;
`ifdef SYNTAX_ARB_STATS_EN
   localparam int CW = 2;
   logic [NR*CW-1:0] grant_cnt;
`else
   localparam int CW = 8;
`endif
   logic clk = 1'b0;
   logic rst_n;
   logic busy, terr;
   int   n_chk = 0;
   int   n_fail = 0;
   typedef struct {logic [7:0] d; logic [1:0] s; logic drop;} exp_t;
   exp_t q[$];
   syntax_rr_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();
   syntax_rr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(16), .CNT_W(CW)) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus.slave),
      .o_busy(busy),
      .o_timeout_err(terr)
`ifdef SYNTAX_ARB_STATS_EN
      ,
      .o_grant_cnt(grant_cnt)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic push(input logic [7:0] d, input logic [1:0] s, input logic drop);
      exp_t e;
      e.d = d;
      e.s = s;
      e.drop = drop;
      q.push_back(e);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && ((bus.out_valid && bus.out_ready) || terr)) begin
         if (q.size() == 0) chk("unexpected_output", 1, 0);
         else begin
            e = q.pop_front();
            chk(terr ? "abort_expected" : "word_not_dropped", {31'd0, terr}, {31'd0, e.drop});
            if (!terr) begin
               chk("out_data", bus.out_data, e.d);
               chk("out_src", bus.out_src, e.s);
            end
         end
      end
   end
   initial begin
      rst_n = 1'b0;
      bus.out_ready = 1'b1;
      bus.req_valid = 4'b1111;
      bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      @(negedge clk);
      chk("ready_in_reset", bus.req_ready, 0);
      chk("valid_in_reset", bus.out_valid, 0);
      chk("data_in_reset", bus.out_data, 0);
      chk("terr_in_reset", terr, 0);
      bus.req_valid = 4'b0000;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_ready", bus.req_ready, 0);
         chk("idle_valid", bus.out_valid, 0);
         chk("idle_busy", busy, 0);
         step();
      end
      // all four requesting: rotation 0,1,2,3,0 with no bubbles
      bus.req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rr_ready", bus.req_ready, 32'd1 << (i % 4));
         if (i > 0) chk("rr_no_bubble", bus.out_valid, 1);
         push(8'hA0 + 8'(i % 4), 2'(i % 4), 1'b0);
         step();
      end
      bus.req_valid = 4'b0000;
      repeat (3) step();
      // single request from 2
      bus.req_data = {8'hA3, 8'h5C, 8'hA1, 8'hA0};
      bus.req_valid = 4'b0100;
      @(negedge clk);
      chk("single_ready", bus.req_ready, 4'b0100);
      push(8'h5C, 2'd2, 1'b0);
      step();
      bus.req_valid = 4'b0000;
      @(negedge clk);
      chk("single_valid", bus.out_valid, 1);
      chk("single_busy", busy, 1);
      step();
      @(negedge clk);
      chk("single_idle_valid", bus.out_valid, 0);
      chk("single_idle_busy", busy, 0);
      step();
      // stall until watchdog abort
      bus.req_data = {8'hA3, 8'h3D, 8'hA1, 8'h11};
      bus.out_ready = 1'b0;
      bus.req_valid = 4'b0100;
      @(negedge clk);
      chk("stall_ready", bus.req_ready, 4'b0100);
      push(8'h3D, 2'd2, 1'b1);
      step();
      bus.req_valid = 4'b0000;
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         chk("stall_valid", bus.out_valid, 1);
         chk("stall_data", bus.out_data, 8'h3D);
         chk("stall_terr", terr, 0);
         step();
      end
      bus.req_data = {8'hA3, 8'h22, 8'hA1, 8'h11};
      bus.req_valid = 4'b0101;
      @(negedge clk);
      chk("abort_pulse", terr, 1);
      chk("abort_valid", bus.out_valid, 0);
      chk("abort_ready", bus.req_ready, 0);
      step();
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("abort_pulse_end", terr, 0);
      chk("post_abort_ready", bus.req_ready, 4'b0001);
      push(8'h11, 2'd0, 1'b0);
      step();
      @(negedge clk);
      chk("post_abort_ready2", bus.req_ready, 4'b0100);
      push(8'h22, 2'd2, 1'b0);
      step();
      bus.req_valid = 4'b0000;
      repeat (3) step();
      // reset during a held transfer
      bus.req_data = {8'hA3, 8'hA2, 8'h77, 8'h11};
      bus.out_ready = 1'b0;
      bus.req_valid = 4'b0010;
      @(negedge clk);
      chk("rst_xfer_ready", bus.req_ready, 4'b0010);
      step();
      bus.req_valid = 4'b0000;
      @(negedge clk);
      chk("rst_xfer_valid", bus.out_valid, 1);
      #2;
      rst_n = 1'b0;
      bus.req_valid = 4'b1111;
      #1;
      chk("async_rst_valid", bus.out_valid, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_ready", bus.req_ready, 0);
      repeat (2) step();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", bus.req_ready, 4'b0001);
      push(8'h11, 2'd0, 1'b0);
      step();
      bus.req_valid = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("req1_ready", bus.req_ready, 4'b0010);
         push(8'h77, 2'd1, 1'b0);
         step();
      end
      bus.req_valid = 4'b0000;
      for (int i = 0; i < 20 && q.size() != 0; i++) step();
      chk("queue_drained", q.size(), 0);
`ifdef SYNTAX_ARB_STATS_EN
      chk("grant_cnt", grant_cnt, {2'd0, 2'd0, 2'd3, 2'd1});
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
